vram_arbiter: RTL and testbench

- Shares one single-port video RAM (text/attribute cells for the 40x30 VGA system) between three requesters.
  - Video scanout fetcher: absolute priority, fixed latency, never stalled.
  - CPU data port.
  - SPI debug port.
- CPU and debug share the remaining slots round-robin.
- Sits between the RAM instance and the VGA/CPU/SPI-debug blocks inside the system module.

---
 rtl/vram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: scanout fetches have absolute priority, CPU and SPI debug
// share the remaining slots round-robin; reads return through an owner-tag pipeline.
module vram_arbiter #(
   parameter int AWIDTH = 11,
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [AWIDTH-1:0] vid_addr,
   output logic [DWIDTH-1:0] vid_rdata,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DWIDTH-1:0] cpu_rdata,
   output logic              cpu_rdy,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [AWIDTH-1:0] dbg_addr,
   input  logic [DWIDTH-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DWIDTH-1:0] dbg_rdata,
   output logic              dbg_rdy,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DWIDTH-1:0] mem_rdata
);
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_CPU  = 2'd2,
      TAG_DBG  = 2'd3
   } tag_e;

   logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic              cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
   logic              last_dbg_q, last_dbg_d;
   tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
   logic [DWIDTH-1:0] vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic              vid_valid_q, vid_valid_d, cpu_rdy_q, cpu_rdy_d, dbg_rdy_q, dbg_rdy_d;
   logic              cpu_elig, dbg_elig, cpu_win, dbg_win;

   // Arbitration, grant loading and read-return steering.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      last_dbg_d  = last_dbg_q;
      tag1_d      = TAG_NONE;
      tag2_d      = tag1_q;
      vid_rdata_d = vid_rdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      vid_valid_d = 1'b0;
      cpu_rdy_d   = 1'b0;
      dbg_rdy_d   = 1'b0;

      // A requester is ignored during its own ack cycle, capping it at one grant per two cycles.
      cpu_elig = cpu_req & ~cpu_ack_q;
      dbg_elig = dbg_req & ~dbg_ack_q;
      cpu_win  = ~vid_req & cpu_elig & (~dbg_elig | last_dbg_q);
      dbg_win  = ~vid_req & dbg_elig & ~cpu_win;

      if (vid_req) begin
         mem_addr_d = vid_addr;
         mem_re_d   = 1'b1;
         tag1_d     = TAG_VID;
      end else if (cpu_win) begin
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
         mem_we_d    = cpu_we;
         mem_re_d    = ~cpu_we;
         cpu_ack_d   = 1'b1;
         last_dbg_d  = 1'b0;
         tag1_d      = cpu_we ? TAG_NONE : TAG_CPU;
      end else if (dbg_win) begin
         mem_addr_d  = dbg_addr;
         mem_wdata_d = dbg_wdata;
         mem_we_d    = dbg_we;
         mem_re_d    = ~dbg_we;
         dbg_ack_d   = 1'b1;
         last_dbg_d  = 1'b1;
         tag1_d      = dbg_we ? TAG_NONE : TAG_DBG;
      end else begin
         mem_we_d = 1'b0;
         mem_re_d = 1'b0;
      end

      case (tag2_q)
         TAG_VID: begin
            vid_rdata_d = mem_rdata;
            vid_valid_d = 1'b1;
         end
         TAG_CPU: begin
            cpu_rdata_d = mem_rdata;
            cpu_rdy_d   = 1'b1;
         end
         TAG_DBG: begin
            dbg_rdata_d = mem_rdata;
            dbg_rdy_d   = 1'b1;
         end
         default: begin
            vid_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset also flushes in-flight read ownership.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q  <= {AWIDTH{1'b0}};
         mem_wdata_q <= {DWIDTH{1'b0}};
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         last_dbg_q  <= 1'b1;
         tag1_q      <= TAG_NONE;
         tag2_q      <= TAG_NONE;
         vid_rdata_q <= {DWIDTH{1'b0}};
         cpu_rdata_q <= {DWIDTH{1'b0}};
         dbg_rdata_q <= {DWIDTH{1'b0}};
         vid_valid_q <= 1'b0;
         cpu_rdy_q   <= 1'b0;
         dbg_rdy_q   <= 1'b0;
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         last_dbg_q  <= last_dbg_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         vid_rdata_q <= vid_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         vid_valid_q <= vid_valid_d;
         cpu_rdy_q   <= cpu_rdy_d;
         dbg_rdy_q   <= dbg_rdy_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign vid_rdata = vid_rdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign vid_valid = vid_valid_q;
   assign cpu_rdy   = cpu_rdy_q;
   assign dbg_rdy   = dbg_rdy_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM environment, transaction-level reference model,
// directed scenario tasks and a randomized traffic run.
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
   logic [10:0] vid_addr = 11'd0, cpu_addr = 11'd0, dbg_addr = 11'd0;
   logic [15:0] cpu_wdata = 16'd0, dbg_wdata = 16'd0;
   logic [15:0] vid_rdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic        vid_valid, cpu_ack, cpu_rdy, dbg_ack, dbg_rdy, mem_we, mem_re;
   logic [10:0] mem_addr;
   logic [15:0] ram    [0:2047];
   logic [15:0] shadow [0:2047];

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rdy(dbg_rdy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   // Single-port synchronous RAM: read data appears the cycle after mem_re.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   logic [81:0] dut_all;
   assign dut_all = {mem_re, mem_we, cpu_ack, dbg_ack, vid_valid, cpu_rdy, dbg_rdy,
                     mem_addr, mem_wdata, vid_rdata, cpu_rdata, dbg_rdata};

   // Reference model: expected outputs of the current cycle plus pending read completions.
   typedef struct { int due; int owner; logic [15:0] data; } rd_t;
   rd_t         pend[$];
   int          total = 0, bad = 0, cyc = 0, last_gnt = 2;
   logic [6:0]  e_ctl = 7'd0;
   logic [10:0] e_addr = 11'd0;
   logic [15:0] e_wdata = 16'd0, e_vd = 16'd0, e_cd = 16'd0, e_dd = 16'd0;

   function automatic logic [81:0] exp_all();
      return {e_ctl, e_addr, e_wdata, e_vd, e_cd, e_dd};
   endfunction

   function automatic logic [15:0] pat(int a);
      return 16'(a * 257) ^ 16'h3C5A;
   endfunction

   task automatic model_step();
      logic [6:0] n;
      logic cpu_ok, dbg_ok;
      n = 7'd0;
      if (reset) begin
         e_ctl = 7'd0; e_addr = 11'd0; e_wdata = 16'd0;
         e_vd = 16'd0; e_cd = 16'd0; e_dd = 16'd0;
         last_gnt = 2;
         pend.delete();
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            case (pend[0].owner)
               0: begin n[2] = 1'b1; e_vd = pend[0].data; end
               1: begin n[1] = 1'b1; e_cd = pend[0].data; end
               default: begin n[0] = 1'b1; e_dd = pend[0].data; end
            endcase
            void'(pend.pop_front());
         end
         cpu_ok = cpu_req && !e_ctl[4];
         dbg_ok = dbg_req && !e_ctl[3];
         if (vid_req) begin
            n[6] = 1'b1; e_addr = vid_addr;
            pend.push_back('{cyc + 3, 0, shadow[vid_addr]});
         end else if (cpu_ok && (!dbg_ok || last_gnt == 2)) begin
            n[4] = 1'b1; e_addr = cpu_addr; e_wdata = cpu_wdata; last_gnt = 1;
            if (cpu_we) begin n[5] = 1'b1; shadow[cpu_addr] = cpu_wdata; end
            else begin n[6] = 1'b1; pend.push_back('{cyc + 3, 1, shadow[cpu_addr]}); end
         end else if (dbg_ok) begin
            n[3] = 1'b1; e_addr = dbg_addr; e_wdata = dbg_wdata; last_gnt = 2;
            if (dbg_we) begin n[5] = 1'b1; shadow[dbg_addr] = dbg_wdata; end
            else begin n[6] = 1'b1; pend.push_back('{cyc + 3, 2, shadow[dbg_addr]}); end
         end
         e_ctl = n;
      end
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); total++;
         if (dut_all !== 82'd0) begin bad++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc, dut_all); end
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(); total++;
         if (dut_all !== 82'd0) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=0", cyc, dut_all); end
      end
   endtask

   task automatic test_video_latency();
      for (int k = 0; k < 9; k++) begin
         vid_req = (k == 5); vid_addr = 11'h123;
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL vid_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         vid_req = 1'b0;
         if (k == 5) begin
            total++;
            if (mem_addr !== 11'h123 || mem_re !== 1'b1) begin bad++; $display("FAIL vid_issue got addr=%h re=%b exp 123/1", mem_addr, mem_re); end
         end
         if (k == 7 || k == 8) begin
            total++;
            if (vid_valid !== (k == 7) || vid_rdata !== 16'hBEEF) begin bad++; $display("FAIL vid_return k=%0d got v=%b d=%h exp v=%b d=beef", k, vid_valid, vid_rdata, k == 7); end
         end
      end
   endtask

   task automatic test_preempt();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
      vid_req = 1'b1; vid_addr = 11'h020;
      for (int k = 1; k <= 6; k++) begin
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL preempt_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         vid_req = 1'b0;
         if (k == 1) begin
            total++;
            if (mem_addr !== 11'h020 || mem_re !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL preempt_vid got addr=%h re=%b ack=%b exp 020/1/0", mem_addr, mem_re, cpu_ack); end
         end
         if (k == 2) begin
            total++;
            if (mem_addr !== 11'h010 || cpu_ack !== 1'b1) begin bad++; $display("FAIL preempt_cpu got addr=%h ack=%b exp 010/1", mem_addr, cpu_ack); end
            cpu_req = 1'b0;
         end
         if (k == 3) begin
            total++;
            if (vid_valid !== 1'b1 || vid_rdata !== pat(32'h020) || cpu_rdy !== 1'b0) begin bad++; $display("FAIL preempt_vvalid got v=%b d=%h r=%b exp 1/%h/0", vid_valid, vid_rdata, cpu_rdy, pat(32'h020)); end
         end
         if (k == 4) begin
            total++;
            if (cpu_rdy !== 1'b1 || cpu_rdata !== pat(32'h010)) begin bad++; $display("FAIL preempt_rdy got r=%b d=%h exp 1/%h", cpu_rdy, cpu_rdata, pat(32'h010)); end
         end
      end
   endtask

   task automatic test_round_robin();
      reset = 1'b1; tick(); reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h200;
      for (int k = 1; k <= 8; k++) begin
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         total++;
         if (cpu_ack !== k[0] || dbg_ack !== !k[0]) begin bad++; $display("FAIL rr_order k=%0d got c=%b d=%b exp c=%b d=%b", k, cpu_ack, dbg_ack, k[0], !k[0]); end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL rr_drain cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
      end
   endtask

   task automatic test_write_read();
      int we_cnt = 0, crdy_cnt = 0;
      reset = 1'b1; tick(); reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 16'h5A5A;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h7FF;
      for (int k = 1; k <= 6; k++) begin
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL wr_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         if (mem_we) we_cnt++;
         if (cpu_rdy) crdy_cnt++;
         if (k == 1) begin
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 11'h7FF || mem_wdata !== 16'h5A5A) begin bad++; $display("FAIL wr_issue got we=%b a=%h d=%h exp 1/7ff/5a5a", mem_we, mem_addr, mem_wdata); end
            cpu_req = 1'b0;
         end
         if (k == 2) dbg_req = 1'b0;
         if (k == 4) begin
            total++;
            if (dbg_rdy !== 1'b1 || dbg_rdata !== 16'h5A5A) begin bad++; $display("FAIL rd_after_wr got r=%b d=%h exp 1/5a5a", dbg_rdy, dbg_rdata); end
         end
      end
      total++;
      if (we_cnt != 1 || crdy_cnt != 0) begin bad++; $display("FAIL wr_counts got we=%0d cpu_rdy=%0d exp 1/0", we_cnt, crdy_cnt); end
   endtask

   task automatic test_reset_mid_read();
      int rdy_cnt = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
      for (int k = 1; k <= 8; k++) begin
         reset = (k == 3);
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL rst_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         cpu_req = 1'b0; reset = 1'b0;
         if (cpu_rdy) rdy_cnt++;
      end
      total++;
      if (rdy_cnt != 0 || cpu_rdata !== 16'h0000) begin bad++; $display("FAIL rst_flush got rdy=%0d d=%h exp 0/0000", rdy_cnt, cpu_rdata); end
      cpu_req = 1'b1; cpu_addr = 11'h055;
      for (int k = 1; k <= 3; k++) begin
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL rst_next_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
         cpu_req = 1'b0;
      end
      total++;
      if (cpu_rdy !== 1'b1 || cpu_rdata !== pat(32'h055)) begin bad++; $display("FAIL rst_next got r=%b d=%h exp 1/%h", cpu_rdy, cpu_rdata, pat(32'h055)); end
   endtask

   function automatic logic [10:0] rand_addr();
      return ($urandom_range(0, 4) == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
   endfunction

   task automatic test_random();
      int vid_gap = 3;
      for (int k = 0; k < 800; k++) begin
         reset = ($urandom_range(0, 149) == 0);
         if (!cpu_req || e_ctl[4]) begin
            cpu_req = ($urandom_range(0, 2) != 0); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
         end
         if (!dbg_req || e_ctl[3]) begin
            dbg_req = ($urandom_range(0, 2) != 0); dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = rand_addr(); dbg_wdata = 16'($urandom);
         end
         if (vid_gap >= 3 && $urandom_range(0, 1) == 1) begin
            vid_req = 1'b1; vid_addr = rand_addr(); vid_gap = 0;
         end else begin
            vid_req = 1'b0; vid_gap++;
         end
         tick(); total++;
         if (dut_all !== exp_all()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all()); end
      end
      reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         ram[i] = pat(i);
         shadow[i] = pat(i);
      end
      ram[11'h123] = 16'hBEEF;
      shadow[11'h123] = 16'hBEEF;
      test_reset();
      test_video_latency();
      test_preempt();
      test_round_robin();
      test_write_read();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
